result_text_formatter: RTL and testbench
========================================

# result_text_formatter

Downstream of the matrix compute stage. Latches a finished result (dimensions, flat 16-bit element array, display type) on the compute stage's one-cycle display strobe. Serialises it as ASCII text, row-major, one byte at a time over a valid/ready byte stream to the UART transmitter. Decimal conversion is sequential: double-dabble, one bit per cycle.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; one clock, reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- display_en  in  1  one-cycle strobe from compute stage: result available
- display_type  in  2  01 = matrix result, 10 = error, 00/11 = ignored
- result_m  in  4  result rows
- result_n  in  4  result columns
- result_mat_flat  in  400  25 × 16-bit unsigned elements; (r,c) at bits [(r*n+c)*16 +: 16]
- tx_data  out  8  ASCII byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts byte
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last byte accepted
- overrun  out  1  one-cycle pulse: display_en with type 01/10 arrived while busy

## Operation
- States: IDLE, LOAD, CONV, DIG, SEP, CR, LF, ERR_TXT, DONE. With macro: HDR states before LOAD.
- IDLE, display_en=1, type 01:
  - latch m, n, matrix → LOAD; busy=1.
  - If m or n is 0 or >5, or m*n > 25: treat as type 10.
- IDLE, display_en=1, type 10: → ERR_TXT; emits "ERR\r\n" (0x45 0x52 0x52 0x0D 0x0A).
- Type 00/11: ignored; nothing latched, no pulse.
- LOAD (1 cycle): select element (row, col); clear BCD.
- CONV (exactly 16 cycles): double-dabble of the 16-bit value into 5 BCD digits.
- DIG: emit digits MSB first, suppressing leading zeros; value 0 emits "0". Max 65535 → 5 bytes.
- After each element:
  - not last column: SEP emits 0x20.
  - last column: CR 0x0D then LF 0x0A.
  - then LOAD the next element, or DONE after the last row.
- DONE (1 cycle): frame_done=1, busy=0, → IDLE.
- Byte handshake:
  - a byte transfers on a clock edge with tx_valid & tx_ready.
  - once tx_valid is asserted, tx_data is held stable and tx_valid is not withdrawn until transfer.
  - tx_valid may rise regardless of tx_ready.
- display_en (type 01/10) while busy: overrun pulses the following cycle; the current frame is unaffected; the new result is discarded.
- Reset (any time, including mid-frame):
  - tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0; state IDLE; partial frame abandoned.
  - no trailing bytes after release.

## Timing
- Inputs are sampled only on the display_en edge; result_mat_flat may change afterwards.
- busy rises the cycle after the display_en edge.
- Error frame: first tx_valid the cycle after latch.
- Matrix frame: first tx_valid 18 cycles after the latch edge (LOAD 1 + CONV 16 + 1).
- Per element with tx_ready held 1: 17 + digit count + separator byte count cycles.
- Each byte occupies ≥1 cycle; back-to-back bytes within an element have no bubbles.
- frame_done pulses the cycle after the last LF transfers; busy falls in that same cycle.
- A new display_en is accepted in that cycle or later.

## Configuration
- RESULT_HEADER_EN defined:
  - each matrix frame is prefixed with header "<m>x<n>\r\n", e.g. "2x3\r\n" (5 bytes).
  - header is emitted before the first LOAD, so the first digit is delayed accordingly.
  - error frames get no header.
- Undefined: no header; the first byte is the first digit of element (0,0).

## Test plan
- 2×2 [1,2;3,4], type 01, tx_ready=1 → "1 2\r\n3 4\r\n" (10 bytes); first tx_valid 18 cycles after strobe; a single frame_done.
- type 10; separately type 01 with m=0, n=3 → each gives "ERR\r\n" then frame_done; type 00 → no bytes, busy stays 0.
- 1×2 [65535,0] with tx_ready randomly toggled → "65535 0\r\n"; tx_data never changes while tx_valid=1 and tx_ready=0.
- 3×1 [7;8;9] busy, second display_en mid-frame → overrun pulses once; output remains "7\r\n8\r\n9\r\n".
- rst asserted after 3 bytes of a 2×2 frame → tx_valid/busy 0 immediately; a following 1×1 [5] frame → exactly "5\r\n".
- With RESULT_HEADER_EN: 2×2 [1,2;3,4] → "2x2\r\n1 2\r\n3 4\r\n"; ERR frame unchanged.

Source files
------------

// File: rtl/result_text_formatter_if.sv
// Byte stream between the result text formatter and the UART transmitter.
// The master drives tx_data and tx_valid. The slave answers with tx_ready.
// A byte transfers on a clock edge where tx_valid and tx_ready are both high.
interface result_text_formatter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_text_formatter.sv
// result_text_formatter
//
// Latches a finished matrix result on the display strobe and streams it as
// ASCII text, row-major, one byte per transfer:
//   - Elements in a row are separated by a space.
//   - Each row ends with CR LF.
//   - Invalid dimensions or an error result produce the text "ERR\r\n".
// Each 16-bit element is converted to decimal by a sequential double-dabble,
// one bit per cycle, and leading zeros are suppressed.
//
// Optional feature: define RESULT_HEADER_EN to prefix each matrix frame with
// a "<m>x<n>\r\n" header line. Error frames never carry a header.
module result_text_formatter (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           display_en,
    input  logic [1:0]                     display_type,
    input  logic [3:0]                     result_m,
    input  logic [3:0]                     result_n,
    input  logic [399:0]                   result_mat_flat,
    result_text_formatter_if.master        tx,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam logic [1:0] TYPE_MATRIX = 2'b01;
    localparam logic [1:0] TYPE_ERROR  = 2'b10;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CONV,
        S_DIG,
        S_SEP,
        S_CR,
        S_LF,
        S_ERR_TXT,
        S_DONE
    } state_t;

    state_t         state;
    logic [399:0]   mat_q;      // latched element array
    logic [2:0]     m_q;        // latched rows (1..5)
    logic [2:0]     n_q;        // latched columns (1..5)
    logic [2:0]     row_q;
    logic [2:0]     col_q;
    logic [15:0]    val_q;      // binary shift register of the element being converted
    logic [19:0]    bcd_q;      // five BCD digits, digit 4 is the most significant
    logic [3:0]     conv_cnt;
    logic [2:0]     dig_idx;    // BCD digit currently on tx_data
    logic [2:0]     txt_idx;    // position inside the fixed error/header text

    logic           xfer;
    logic           can_accept;
    logic           new_frame;
    logic           dims_ok;
    logic [4:0]     elem_idx;
    logic [19:0]    bcd_adj;
    logic [19:0]    bcd_next;
    logic [2:0]     lead_idx;
    logic [3:0]     lead_digit;
    logic [2:0]     dig_down;
    logic [3:0]     next_digit;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] err_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h45;  // 'E'
            3'd1:    return 8'h52;  // 'R'
            3'd2:    return 8'h52;  // 'R'
            3'd3:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

`ifdef RESULT_HEADER_EN
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx,
                                            input logic [2:0] m,
                                            input logic [2:0] n);
        case (idx)
            3'd0:    return 8'h30 + {5'h0, m};
            3'd1:    return 8'h78;  // 'x'
            3'd2:    return 8'h30 + {5'h0, n};
            3'd3:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction
`endif

    assign xfer       = tx.tx_valid & tx.tx_ready;
    assign can_accept = (state == S_IDLE) || (state == S_DONE);
    assign new_frame  = display_en &&
                        ((display_type == TYPE_MATRIX) || (display_type == TYPE_ERROR));
    assign dims_ok    = (result_m != 4'd0) && (result_n != 4'd0) &&
                        (result_m <= 4'd5) && (result_n <= 4'd5) &&
                        (({4'h0, result_m} * {4'h0, result_n}) <= 8'd25);
    assign elem_idx   = 5'(row_q) * 5'(n_q) + 5'(col_q);

    // Double-dabble step, leading-digit search and next-digit select.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves one unassigned and no latch is inferred.
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[18:0], val_q[15]};

        lead_idx = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_next[i*4 +: 4] != 4'd0) begin
                lead_idx = 3'(i);
            end
        end
        lead_digit = bcd_next[lead_idx*4 +: 4];

        dig_down   = (dig_idx == 3'd0) ? 3'd0 : dig_idx - 3'd1;
        next_digit = bcd_q[dig_down*4 +: 4];
    end

    // Element array capture when a matrix frame is accepted.
    // NOTE: this is plain data that is qualified by the frame state.
    // It carries no reset, so it stays out of the reset network.
    always_ff @(posedge clk) begin
        if (can_accept && display_en && (display_type == TYPE_MATRIX)) begin
            mat_q <= result_mat_flat;
        end
    end

    // Frame sequencer. All outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= S_IDLE;
            tx.tx_data  <= 8'h00;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            m_q         <= 3'd0;
            n_q         <= 3'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            val_q       <= 16'd0;
            bcd_q       <= 20'd0;
            conv_cnt    <= 4'd0;
            dig_idx     <= 3'd0;
            txt_idx     <= 3'd0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= !can_accept && new_frame;

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (new_frame) begin
                        busy    <= 1'b1;
                        txt_idx <= 3'd0;
                        if ((display_type == TYPE_MATRIX) && dims_ok) begin
                            m_q   <= result_m[2:0];
                            n_q   <= result_n[2:0];
                            row_q <= 3'd0;
                            col_q <= 3'd0;
`ifdef RESULT_HEADER_EN
                            state       <= S_HDR;
                            tx.tx_data  <= hdr_byte(3'd0, result_m[2:0], result_n[2:0]);
                            tx.tx_valid <= 1'b1;
`else
                            state <= S_LOAD;
`endif
                        end else begin
                            state       <= S_ERR_TXT;
                            tx.tx_data  <= err_byte(3'd0);
                            tx.tx_valid <= 1'b1;
                        end
                    end
                end

`ifdef RESULT_HEADER_EN
                S_HDR: begin
                    if (xfer) begin
                        if (txt_idx == 3'd4) begin
                            tx.tx_valid <= 1'b0;
                            state       <= S_LOAD;
                        end else begin
                            txt_idx    <= txt_idx + 3'd1;
                            tx.tx_data <= hdr_byte(txt_idx + 3'd1, m_q, n_q);
                        end
                    end
                end
`endif

                S_LOAD: begin
                    val_q    <= mat_q[{elem_idx, 4'b0000} +: 16];
                    bcd_q    <= 20'd0;
                    conv_cnt <= 4'd0;
                    state    <= S_CONV;
                end

                S_CONV: begin
                    val_q    <= {val_q[14:0], 1'b0};
                    bcd_q    <= bcd_next;
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd15) begin
                        // The leading digit comes straight from the final shift, so the
                        // first character is ready the cycle after the conversion.
                        dig_idx     <= lead_idx;
                        tx.tx_data  <= ascii_digit(lead_digit);
                        tx.tx_valid <= 1'b1;
                        state       <= S_DIG;
                    end
                end

                S_DIG: begin
                    if (xfer) begin
                        if (dig_idx == 3'd0) begin
                            if (col_q == n_q - 3'd1) begin
                                tx.tx_data <= ASCII_CR;
                                state      <= S_CR;
                            end else begin
                                tx.tx_data <= ASCII_SPACE;
                                state      <= S_SEP;
                            end
                        end else begin
                            dig_idx    <= dig_down;
                            tx.tx_data <= ascii_digit(next_digit);
                        end
                    end
                end

                S_SEP: begin
                    if (xfer) begin
                        tx.tx_valid <= 1'b0;
                        col_q       <= col_q + 3'd1;
                        state       <= S_LOAD;
                    end
                end

                S_CR: begin
                    if (xfer) begin
                        tx.tx_data <= ASCII_LF;
                        state      <= S_LF;
                    end
                end

                S_LF: begin
                    if (xfer) begin
                        tx.tx_valid <= 1'b0;
                        if (row_q == m_q - 3'd1) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            row_q <= row_q + 3'd1;
                            col_q <= 3'd0;
                            state <= S_LOAD;
                        end
                    end
                end

                S_ERR_TXT: begin
                    if (xfer) begin
                        if (txt_idx == 3'd4) begin
                            tx.tx_valid <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            txt_idx    <= txt_idx + 3'd1;
                            tx.tx_data <= err_byte(txt_idx + 3'd1);
                        end
                    end
                end

                default: begin
                    tx.tx_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_text_formatter.sv
// Directed self-checking bench for result_text_formatter.
// Expected bytes are queued when a frame is launched. A per-cycle monitor
// pops and compares them as the stream transfers them.
// When RESULT_HEADER_EN is defined, the expected frames include the header.
module tb_result_text_formatter;

`ifdef RESULT_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int HDR_CYC = HDR ? 5 : 0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           display_en = 1'b0;
    logic [1:0]     display_type = 2'b00;
    logic [3:0]     result_m = 4'd0;
    logic [3:0]     result_n = 4'd0;
    logic [399:0]   result_mat_flat = '0;
    logic           busy;
    logic           frame_done;
    logic           overrun;

    result_text_formatter_if bus ();

    result_text_formatter dut (
        .clk             (clk),
        .rst             (rst),
        .display_en      (display_en),
        .display_type    (display_type),
        .result_m        (result_m),
        .result_n        (result_n),
        .result_mat_flat (result_mat_flat),
        .tx              (bus),
        .busy            (busy),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          cycle = 0;
    int          strobe_cycle = 0;
    int          bytes_seen = 0;
    int          fd_count = 0;
    int          fd_rel = -1;
    logic        fd_busy = 1'b1;
    int          ov_count = 0;
    int          ov_cycle = -1;
    int          first_valid_rel = -1;
    int          holds_seen = 0;
    bit          busy_seen = 1'b0;
    bit          hold_pending = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Sampled at the falling edge: decides what the next rising edge transfers.
    task automatic monitor();
        int rel;
        rel = cycle - strobe_cycle + 1;
        if (rst) begin
            hold_pending = 1'b0;
            return;
        end
        if (busy) busy_seen = 1'b1;
        if (frame_done) begin
            fd_count++;
            fd_rel  = rel;
            fd_busy = busy;
        end
        if (overrun) begin
            ov_count++;
            ov_cycle = cycle;
        end
        if (bus.tx_valid && first_valid_rel < 0) first_valid_rel = rel;
        if (hold_pending) begin
            check("hold_valid", 32'(bus.tx_valid), 32'd1);
            check("hold_data", 32'(bus.tx_data), 32'(hold_data));
            holds_seen++;
        end
        hold_pending = bus.tx_valid && !bus.tx_ready;
        hold_data    = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) begin
            bytes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
                check("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle++;
        bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    function automatic string hdr(input int m, input int n);
        return HDR ? $sformatf("%0dx%0d\r\n", m, n) : "";
    endfunction

    function automatic logic [399:0] put(input logic [399:0] f, input int idx, input logic [15:0] v);
        logic [399:0] r;
        r = f;
        r[idx*16 +: 16] = v;
        return r;
    endfunction

    task automatic strobe(input logic [1:0] t, input logic [3:0] m, input logic [3:0] n,
                          input logic [399:0] flat);
        display_en      = 1'b1;
        display_type    = t;
        result_m        = m;
        result_n        = n;
        result_mat_flat = flat;
        first_valid_rel = -1;
        fd_rel          = -1;
        tick();
        strobe_cycle    = cycle;
        display_en      = 1'b0;
        display_type    = 2'b00;
        result_m        = 4'hF;
        result_n        = 4'hF;
        result_mat_flat = {13{$urandom()}};
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int start;
        int n;
        start = fd_count;
        n = 0;
        while (fd_count == start && n < budget) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) tick();
        check(tag, 32'(fd_count - start), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [399:0] f;
        int base;
        int n;
        int s2;

        bus.tx_ready = 1'b1;
        #2;
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 2x2 [1,2;3,4] with tx_ready held high: latency and frame timing.
        f = '0;
        f = put(f, 0, 16'd1);
        f = put(f, 1, 16'd2);
        f = put(f, 2, 16'd3);
        f = put(f, 3, 16'd4);
        push_str({hdr(2, 2), "1 2\r\n3 4\r\n"});
        base = bytes_seen;
        strobe(2'b01, 4'd2, 4'd2, f);
        check("busy_after_strobe", 32'(busy), 32'd1);
        wait_frame("mat2x2_done", 300);
        check("mat2x2_first_valid", 32'(first_valid_rel), HDR ? 32'd1 : 32'd18);
        check("mat2x2_done_cycle", 32'(fd_rel), 32'(79 + HDR_CYC));
        check("mat2x2_done_busy", 32'(fd_busy), 32'd0);
        check("mat2x2_bytes", 32'(bytes_seen - base), 32'(10 + HDR_CYC));

        // Error result.
        push_str("ERR\r\n");
        strobe(2'b10, 4'd2, 4'd2, f);
        wait_frame("err_done", 50);
        check("err_first_valid", 32'(first_valid_rel), 32'd1);
        check("err_done_cycle", 32'(fd_rel), 32'd6);

        // Matrix result with a zero dimension becomes an error frame.
        push_str("ERR\r\n");
        strobe(2'b01, 4'd0, 4'd3, f);
        wait_frame("zero_dim_done", 50);

        // Ignored display type: no bytes, never busy.
        busy_seen = 1'b0;
        base = fd_count;
        strobe(2'b00, 4'd2, 4'd2, f);
        for (int i = 0; i < 30; i++) tick();
        check("type00_busy", 32'(busy_seen), 32'd0);
        check("type00_no_done", 32'(fd_count - base), 32'd0);

        // 1x2 [65535,0] with a randomly stalling receiver.
        f = '0;
        f = put(f, 0, 16'hFFFF);
        push_str({hdr(1, 2), "65535 0\r\n"});
        holds_seen = 0;
        rand_ready = 1'b1;
        strobe(2'b01, 4'd1, 4'd2, f);
        wait_frame("max_val_done", 500);
        rand_ready = 1'b0;
        tick();
        check("stalls_exercised", 32'(holds_seen > 0), 32'd1);

        // 3x1 [7;8;9] with a second result arriving mid-frame.
        f = '0;
        f = put(f, 0, 16'd7);
        f = put(f, 1, 16'd8);
        f = put(f, 2, 16'd9);
        push_str({hdr(3, 1), "7\r\n8\r\n9\r\n"});
        ov_count = 0;
        strobe(2'b01, 4'd3, 4'd1, f);
        for (int i = 0; i < 10; i++) tick();
        display_en      = 1'b1;
        display_type    = 2'b01;
        result_m        = 4'd1;
        result_n        = 4'd1;
        result_mat_flat = put('0, 0, 16'd3);
        tick();
        s2 = cycle;
        display_en   = 1'b0;
        display_type = 2'b00;
        wait_frame("overrun_frame_done", 300);
        check("overrun_count", 32'(ov_count), 32'd1);
        check("overrun_cycle", 32'(ov_cycle), 32'(s2));

        // Reset after three bytes of a 2x2 frame, then a clean 1x1 frame.
        begin
            string full;
            full = {hdr(2, 2), "1 2\r\n3 4\r\n"};
            push_str(full.substr(0, 2));
        end
        f = '0;
        f = put(f, 0, 16'd1);
        f = put(f, 1, 16'd2);
        f = put(f, 2, 16'd3);
        f = put(f, 3, 16'd4);
        base = bytes_seen;
        strobe(2'b01, 4'd2, 4'd2, f);
        n = 0;
        while (bytes_seen - base < 3 && n < 200) begin
            tick();
            n++;
        end
        check("pre_reset_bytes", 32'(bytes_seen - base), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        base = fd_count;
        for (int i = 0; i < 40; i++) tick();
        check("post_reset_no_done", 32'(fd_count - base), 32'd0);
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);

        f = put('0, 0, 16'd5);
        push_str({hdr(1, 1), "5\r\n"});
        base = bytes_seen;
        strobe(2'b01, 4'd1, 4'd1, f);
        wait_frame("one_by_one_done", 100);
        check("one_by_one_bytes", 32'(bytes_seen - base), 32'(3 + HDR_CYC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
